// File: rtl/gal_olmc_bank_if.sv
// gal_olmc_bank_if
// Bundles the per-channel control, data and pin signals of the GAL output
// logic macrocell bank. Clock (C) and reset (R) stay as plain module ports.
//   SP      : synchronous preset, active-high
//   PL      : synchronous preload strobe, active-high
//   PL_DATA : preload value, one bit per channel
//   D       : sum-of-products result, one bit per channel
//   OE      : product-term output enable per channel
//   PIN     : pin sense input used as combinational feedback
//   Y       : pin data
//   Y_OE    : pin drive enable
//   FB      : feedback into the AND array
// The master modport drives the array side; the slave modport is the bank.
interface gal_olmc_bank_if #(
  parameter int CHANNELS = 8
);
  logic                SP;
  logic                PL;
  logic [CHANNELS-1:0] PL_DATA;
  logic [CHANNELS-1:0] D;
  logic [CHANNELS-1:0] OE;
  logic [CHANNELS-1:0] PIN;
  logic [CHANNELS-1:0] Y;
  logic [CHANNELS-1:0] Y_OE;
  logic [CHANNELS-1:0] FB;

  modport master (
    output SP, PL, PL_DATA, D, OE, PIN,
    input  Y, Y_OE, FB
  );

  modport slave (
    input  SP, PL, PL_DATA, D, OE, PIN,
    output Y, Y_OE, FB
  );
endinterface

// File: rtl/gal_olmc_bank.sv
// gal_olmc_bank
// A bank of CHANNELS output logic macrocells in the style of a GAL device.
// Each channel is either registered (REG_MASK bit set) or combinational,
// and its pin data may be inverted (INV_MASK bit set).
// Ports:
//   C   : clock, state updates on the rising edge
//   R   : asynchronous active-low reset, clears all state bits
//   bus : gal_olmc_bank_if slave modport (SP, PL, PL_DATA, D, OE, PIN in;
//         Y, Y_OE, FB out)
// Registered channel: q <= PL ? PL_DATA : SP ? 1 : D; Y = q ^ INV; FB = q.
// Combinational channel: no flop, Y = D ^ INV; FB = PIN.
// Y_OE follows OE in both modes.
module gal_olmc_bank #(
  parameter int                 CHANNELS = 8,
  parameter logic [CHANNELS-1:0] REG_MASK = '1,
  parameter logic [CHANNELS-1:0] INV_MASK = '0
) (
  input logic             C,
  input logic             R,
  gal_olmc_bank_if.slave  bus
);

  // State bits; combinational channels tie their bit to 0 and get no flop.
  logic [CHANNELS-1:0] q_s;
  logic [CHANNELS-1:0] y_s;
  logic [CHANNELS-1:0] fb_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    if (REG_MASK[i]) begin : g_reg
      logic q_r;

      // Macrocell flop: reset wins over everything, then preload, then preset.
      always_ff @(posedge C or negedge R) begin
        if (!R) begin
          q_r <= 1'b0;
        end else if (bus.PL) begin
          q_r <= bus.PL_DATA[i];
        end else if (bus.SP) begin
          q_r <= 1'b1;
        end else begin
          q_r <= bus.D[i];
        end
      end

      assign q_s[i] = q_r;
    end else begin : g_comb
      assign q_s[i] = 1'b0;
    end
  end

  // Pin data and feedback selection per channel mode (mode is a constant).
  always_comb begin
    y_s  = '0;
    fb_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (REG_MASK[i]) begin
        y_s[i]  = q_s[i] ^ INV_MASK[i];
        fb_s[i] = q_s[i];
      end else begin
        y_s[i]  = bus.D[i] ^ INV_MASK[i];
        fb_s[i] = bus.PIN[i];
      end
    end
  end

  assign bus.Y    = y_s;
  assign bus.Y_OE = bus.OE;
  assign bus.FB   = fb_s;

endmodule

// File: tb/tb_gal_olmc_bank.sv
module tb_gal_olmc_bank;
  localparam int CH = 4;

  logic C;
  logic R;
  int   errors;
  int   checks;

  gal_olmc_bank_if #(.CHANNELS(CH)) bus ();

  gal_olmc_bank #(
    .CHANNELS (CH),
    .REG_MASK (4'b0011),
    .INV_MASK (4'b0101)
  ) dut (
    .C   (C),
    .R   (R),
    .bus (bus)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Wait for a rising edge, then settle before sampling.
  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic test_reset();
    R = 1'b0;
    bus.SP = 1'b0; bus.PL = 1'b0; bus.PL_DATA = 4'b0000;
    bus.D = 4'b0000; bus.OE = 4'b1111; bus.PIN = 4'b0000;
    #3;
    checks++;
    if (bus.Y !== 4'b0101) begin errors++; $display("FAIL reset_y: got %b want %b", bus.Y, 4'b0101); end
    checks++;
    if (bus.Y_OE !== 4'b1111) begin errors++; $display("FAIL reset_yoe: got %b want %b", bus.Y_OE, 4'b1111); end
    checks++;
    if (bus.FB !== 4'b0000) begin errors++; $display("FAIL reset_fb: got %b want %b", bus.FB, 4'b0000); end
    tick();
    checks++;
    if (bus.FB[1:0] !== 2'b00) begin errors++; $display("FAIL reset_hold_q: got %b want %b", bus.FB[1:0], 2'b00); end
  endtask

  task automatic test_load();
    R = 1'b1; bus.SP = 1'b0; bus.PL = 1'b0; bus.D = 4'b0011;
    tick();
    checks++;
    if (bus.FB[1:0] !== 2'b11) begin errors++; $display("FAIL load_q: got %b want %b", bus.FB[1:0], 2'b11); end
    checks++;
    if (bus.Y !== 4'b0110) begin errors++; $display("FAIL load_y: got %b want %b", bus.Y, 4'b0110); end
  endtask

  task automatic test_preset();
    // clear first so the preset visibly sets the state
    R = 1'b0; #2; R = 1'b1;
    checks++;
    if (bus.FB[1:0] !== 2'b00) begin errors++; $display("FAIL preset_pre_q: got %b want %b", bus.FB[1:0], 2'b00); end
    bus.SP = 1'b1; bus.D = 4'b0000;
    tick();
    checks++;
    if (bus.FB[1:0] !== 2'b11) begin errors++; $display("FAIL preset_q: got %b want %b", bus.FB[1:0], 2'b11); end
    checks++;
    if (bus.Y !== 4'b0110) begin errors++; $display("FAIL preset_y: got %b want %b", bus.Y, 4'b0110); end
    // combinational channels respond to D with no clock edge
    bus.D = 4'b0100;
    #1;
    checks++;
    if (bus.Y[3:2] !== 2'b00) begin errors++; $display("FAIL preset_comb_y: got %b want %b", bus.Y[3:2], 2'b00); end
    checks++;
    if (bus.FB[1:0] !== 2'b11) begin errors++; $display("FAIL preset_no_clk_q: got %b want %b", bus.FB[1:0], 2'b11); end
    bus.D = 4'b0000;
  endtask

  task automatic test_priority();
    bus.PL = 1'b1; bus.SP = 1'b1; bus.PL_DATA = 4'b1110; bus.D = 4'b0000;
    bus.PIN = 4'b0100;
    tick();
    checks++;
    if (bus.FB[1:0] !== 2'b10) begin errors++; $display("FAIL prio_q: got %b want %b", bus.FB[1:0], 2'b10); end
    checks++;
    if (bus.Y !== 4'b0111) begin errors++; $display("FAIL prio_y: got %b want %b", bus.Y, 4'b0111); end
    checks++;
    if (bus.FB[3:2] !== 2'b01) begin errors++; $display("FAIL prio_fb_comb: got %b want %b", bus.FB[3:2], 2'b01); end
    // preload alone
    bus.SP = 1'b0; bus.PL_DATA = 4'b0001;
    tick();
    checks++;
    if (bus.FB[1:0] !== 2'b01) begin errors++; $display("FAIL pl_only_q: got %b want %b", bus.FB[1:0], 2'b01); end
    bus.PL = 1'b0; bus.PIN = 4'b0000;
  endtask

  task automatic test_mid_reset();
    bus.SP = 1'b1; bus.PL = 1'b0;
    tick();
    checks++;
    if (bus.FB[1:0] !== 2'b11) begin errors++; $display("FAIL midrst_setup_q: got %b want %b", bus.FB[1:0], 2'b11); end
    @(negedge C);
    bus.PL = 1'b1; bus.PL_DATA = 4'b1111; R = 1'b0;
    #1;
    checks++;
    if (bus.FB[1:0] !== 2'b00) begin errors++; $display("FAIL midrst_async_q: got %b want %b", bus.FB[1:0], 2'b00); end
    checks++;
    if (bus.Y[1:0] !== 2'b01) begin errors++; $display("FAIL midrst_async_y: got %b want %b", bus.Y[1:0], 2'b01); end
    tick();
    tick();
    checks++;
    if (bus.FB[1:0] !== 2'b00) begin errors++; $display("FAIL midrst_hold_q: got %b want %b", bus.FB[1:0], 2'b00); end
    // release between edges; first edge uses normal priority
    @(negedge C);
    R = 1'b1; bus.PL = 1'b0; bus.SP = 1'b0; bus.D = 4'b0001;
    #1;
    checks++;
    if (bus.FB[1:0] !== 2'b00) begin errors++; $display("FAIL midrst_release_q: got %b want %b", bus.FB[1:0], 2'b00); end
    tick();
    checks++;
    if (bus.FB[1:0] !== 2'b01) begin errors++; $display("FAIL midrst_first_edge_q: got %b want %b", bus.FB[1:0], 2'b01); end
  endtask

  task automatic test_feedback();
    // q is 2'b01 from the previous scenario
    bus.OE = 4'b0000; bus.PIN = 4'b1010; bus.D = 4'b0001;
    #1;
    checks++;
    if (bus.Y_OE !== 4'b0000) begin errors++; $display("FAIL fb_yoe: got %b want %b", bus.Y_OE, 4'b0000); end
    checks++;
    if (bus.FB !== 4'b1001) begin errors++; $display("FAIL fb_fb: got %b want %b", bus.FB, 4'b1001); end
    bus.OE = 4'b0110; bus.PIN = 4'b0101;
    #1;
    checks++;
    if (bus.Y_OE !== 4'b0110) begin errors++; $display("FAIL fb_yoe2: got %b want %b", bus.Y_OE, 4'b0110); end
    checks++;
    if (bus.FB !== 4'b0101) begin errors++; $display("FAIL fb_fb2: got %b want %b", bus.FB, 4'b0101); end
    bus.OE = 4'b1111; bus.PIN = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [3:0] d_vec [4];
    logic [3:0] y_exp [4];
    d_vec = '{4'b1001, 4'b0110, 4'b1111, 4'b0000};
    // registered bits: q ^ 01; comb bits: D[3:2] ^ 01, sampled after edge
    y_exp = '{4'b1100, 4'b0011, 4'b1010, 4'b0101};
    for (int k = 0; k < 4; k++) begin
      bus.D = d_vec[k];
      tick();
      checks++;
      if (bus.FB[1:0] !== d_vec[k][1:0]) begin
        errors++; $display("FAIL b2b_q[%0d]: got %b want %b", k, bus.FB[1:0], d_vec[k][1:0]);
      end
      checks++;
      if (bus.Y !== y_exp[k]) begin
        errors++; $display("FAIL b2b_y[%0d]: got %b want %b", k, bus.Y, y_exp[k]);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_load();
    test_preset();
    test_priority();
    test_mid_reset();
    test_feedback();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
